// File: rtl/kernel_conv_sequencer.sv
// kernel_conv_sequencer: steps one SIZExSIZE window through the kernel accumulator and captures its scaled sum
module kernel_conv_sequencer #(
    parameter logic [3:0] SIZE = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic       acc_ready,
    input  logic       acc_clear_flag,
    input  logic [7:0] acc_sum,
    output logic       acc_clear,
    output logic       acc_start,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, CLR, CLR_WAIT, ISSUE, HOLD, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic last, first, x_end;
    assign x_end = cur_x == SIZE - 4'd1;
    assign last  = x_end && cur_y == SIZE - 4'd1;
    assign first = cur_x == 4'd0 && cur_y == 4'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = go ? CLR : IDLE;
            CLR:      state_n = CLR_WAIT;
            CLR_WAIT: state_n = acc_clear_flag ? ISSUE : CLR_WAIT;
            ISSUE:    state_n = HOLD;
            HOLD:     state_n = last ? DRAIN : ISSUE;
            DRAIN:    state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_comb begin
        acc_clear = state == CLR;
        acc_start = state == ISSUE;
        busy      = state != IDLE;
        done      = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x  <= 4'd0;
            cur_y  <= 4'd0;
            result <= 8'd0;
            err    <= 1'b0;
        end else begin
            if (abort || state == DONE) begin
                cur_x <= 4'd0;
                cur_y <= 4'd0;
            end else if (state == IDLE && go) begin
                cur_x <= 4'd0;
                cur_y <= 4'd0;
                err   <= 1'b0;
            end else if (state == HOLD) begin
                cur_x <= x_end ? 4'd0 : cur_x + 4'd1;
                cur_y <= x_end ? cur_y + 4'd1 : cur_y;
            end
            if (((state == ISSUE && !first) || state == DRAIN) && !acc_ready) err <= 1'b1;
            if (state == DRAIN && !abort) result <= acc_sum;
        end
    end
endmodule

// File: doc/kernel_conv_sequencer.md
# kernel_conv_sequencer

Controller that runs one SIZE×SIZE convolution window through the kernel accumulator. It clears the accumulator, walks the kernel/pixel window in raster order and drives the buffer read addresses. It issues one accumulator `start` per element and captures the final 8-bit scaled sum. It sits between the window-level scan logic, which pulses `go`, and a single kernel accumulator instance plus the kernel and pixel window buffers, which have combinational reads.

## Interface
- SIZE, 4'd3, kernel dimension; legal range 1..15; N = SIZE*SIZE elements per window
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- go  in  1  start one window; sampled only in IDLE, ignored otherwise
- abort  in  1  synchronous abort; returns to IDLE from any state next cycle
- acc_ready  in  1  accumulator `ready` output
- acc_clear_flag  in  1  accumulator `clear_flag` output
- acc_sum  in  8  accumulator `sum` output (upper byte of 16-bit accumulation)
- acc_clear  out  1  accumulator `clear` input
- acc_start  out  1  accumulator `start` input
- cur_x  out  4  column address to kernel and pixel buffers
- cur_y  out  4  row address to kernel and pixel buffers
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when `result` is valid
- result  out  8  captured window sum; holds until next `done`
- err  out  1  sticky; set when accumulator handshake is violated, cleared on accepted `go`

## Operation
- States: IDLE, CLR, CLR_WAIT, ISSUE, HOLD, DRAIN, DONE.
- IDLE: all strobes low. If `go`=1 the FSM goes to CLR, `cur_x`/`cur_y` load 0 and `err` clears.
- CLR: `acc_clear`=1 for exactly one cycle, then CLR_WAIT.
- CLR_WAIT: waits with no timeout until `acc_clear_flag`=1, then ISSUE.
- ISSUE: `acc_start`=1; address holds current element; next state HOLD.
  - On every ISSUE except the first of a window, `acc_ready` must be 1; otherwise `err` sets and the FSM still proceeds.
- HOLD: `acc_start`=0 and the address stays stable, because the accumulator samples the buffer data in this cycle.
  - On exit the address advances raster order: x increments; when x = SIZE-1, x goes to 0 and y increments.
  - If the element just held was (SIZE-1, SIZE-1), next state is DRAIN; otherwise ISSUE.
- DRAIN: `acc_start`=0, so the accumulator returns to its idle state.
  - `result` <= `acc_sum`.
  - If `acc_ready`=0, `err` sets.
  - Next state DONE.
- DONE: `done`=1 for one cycle, then IDLE. The address resets to 0.
- Arithmetic belongs to the accumulator; this block never modifies `acc_sum`. 16-bit wrap in the accumulator passes through unchanged.
- Abort: takes priority over all transitions.
  - Next cycle state is IDLE, `acc_start`=0, `acc_clear`=0, address 0.
  - No `done`; `result` is unchanged.
  - A partial accumulator sum is discarded by the CLR of the next window.
- `go` and `abort` high together in IDLE: abort wins and the FSM stays in IDLE.
- Reset values: state IDLE; `acc_clear`, `acc_start`, `busy`, `done`, `err` = 0; `cur_x`, `cur_y`, `result` = 0.

## Timing
- Outputs are Moore, decoded from the state register, except the address, which comes from its own registers.
- Cycle 0 is the cycle where `go`=1 in IDLE.
  - CLR at cycle 1, CLR_WAIT at cycle 2 (the accumulator's clear_flag arrives here), first ISSUE at cycle 3.
  - Each element costs 2 cycles (ISSUE, HOLD).
  - DRAIN at cycle 2N+3; `done` at cycle 2N+4, which is 22 for SIZE=3.
  - The next `go` is accepted at cycle 2N+5 at the earliest.
- Back-to-back elements: a non-first ISSUE coincides with the accumulator's compute-idle state (`ready`=1), so `start` goes straight to its sum state with no idle gap.
- `cur_x`/`cur_y` change only on HOLD→ISSUE, HOLD→DRAIN, DONE→IDLE, abort, or `go` acceptance. They are stable for the full ISSUE+HOLD pair.
- SIZE=1: one ISSUE/HOLD pair; `done` at cycle 6.

## Test plan
- Reset and idle: assert `rst` mid-window (in HOLD) → all outputs 0 immediately. After release, `busy`=0 and `acc_start`=0 until `go`.
- Nominal 3×3: kernel all 0x80, pixels all 0x10, `go` at cycle 0 → `done` at cycle 22, `result`=0x48. Address sequence (0,0),(1,0),(2,0),(0,1)…(2,2), each held 2 cycles.
- Wrap passthrough: kernel and pixels all 0xFF, SIZE=3 → `result`=0xEE (16-bit sum 0xEE09), `err`=0.
- Consecutive windows: second `go` at cycle 23 with pixels all 0x20 → `result`=0x90. The prior sum is not carried, because CLR precedes the first ISSUE.
- Abort: `abort` during the 5th ISSUE → IDLE next cycle, no `done`, `result` retains the previous value. A following `go` gives a correct full sum.
- Handshake error: a stub accumulator forces `acc_ready`=0 at the 2nd ISSUE → `err`=1 through `done`; `err` clears when the next `go` is accepted.
